pwm_timebase: RTL and testbench
===============================

# pwm_timebase

Centre-aligned PWM carrier generator for the motor bridge, clocked by the 54 MHz x2 PLL output (27 MHz board oscillator doubled). Produces an up/down triangle counter, valley/peak event strobes and an ADC sampling trigger. Period and prescaler are double-buffered and take effect only at the carrier valley. Downstream comparators and dead-time generators consume `cnt` and the event strobes.

## Interface
- `CNT_W`, 16, width of carrier counter and period
- `PRESC_W`, 8, width of prescaler value
- `DEFAULT_PERIOD`, 1350, active period after reset (20 kHz carrier at 54 MHz, prescaler 0)

- `clk`  in  1  54 MHz PLL output clock
- `rst`  in  1  synchronous, active-high reset
- `enable`  in  1  1 = carrier runs; 0 = freeze
- `period_in`  in  CNT_W  new half-period value P
- `period_wr`  in  1  single-cycle write strobe for `period_in` and `presc_in`
- `presc_in`  in  PRESC_W  new prescaler value; tick every `presc+1` clocks
- `adc_trig_pos`  in  CNT_W  counter value that fires `adc_trig` (up-count only)
- `cnt`  out  CNT_W  carrier counter
- `dir`  out  1  1 = counting up, 0 = counting down
- `zero_evt`  out  1  one-cycle pulse: `cnt` just became 0
- `peak_evt`  out  1  one-cycle pulse: `cnt` just became P
- `period_upd`  out  1  one-cycle pulse: pending period/prescaler loaded
- `adc_trig`  out  1  one-cycle pulse: ADC sample point

## Operation
- Reset values: `cnt`=0, `dir`=1, all event outputs 0, active P=`DEFAULT_PERIOD`, active prescaler 0, prescaler counter 0, pending-valid flag 0.
- Prescaler: counts 0..presc; a tick occurs on the clock where the prescaler counter equals the active presc, then it returns to 0. With presc=0, every clock is a tick.
- Counter, on each tick:
  - `dir`=1 and `cnt+1`==P: `cnt`←P, `dir`←0, `peak_evt`.
  - `dir`=1 otherwise: `cnt`←`cnt+1`.
  - `dir`=0 and `cnt`==1: `cnt`←0, `dir`←1, `zero_evt`, valley load.
  - `dir`=0 otherwise: `cnt`←`cnt-1`.
- Carrier period is 2·P ticks.
- Shadow registers:
  - `period_wr` captures `period_in` (values <2 clamp to 2) and `presc_in` into pending and sets pending-valid. A later write before the valley overwrites the earlier one.
  - Valley load: if pending-valid, active ← pending, clear pending-valid, pulse `period_upd` coincident with `zero_evt`.
  - `period_wr` on the same clock as a valley load: the load uses the pre-existing pending contents, and the new write stays pending for the next valley.
- ADC trigger:
  - Fires on a tick where `dir`=1 and the new `cnt`==`adc_trig_pos`.
  - `adc_trig_pos`=0 fires with `zero_evt`. `adc_trig_pos`=P fires with `peak_evt`. `adc_trig_pos`>P never fires.
- `enable`=0: prescaler counter, `cnt` and `dir` hold, and no events fire. Pending writes are still accepted. Re-asserting `enable` resumes from the held state.
- `rst` mid-carrier returns everything to reset values on the next edge and discards any pending write.

## Timing
- All outputs are registered. Event strobes assert in the same cycle `cnt` first shows the new value, and last exactly one clock regardless of prescaler.
- `period_wr` to effect: no earlier than the next valley. `period_upd` is the only indication that the load happened.
- After `rst` deasserts with `enable`=1 and presc=0: `cnt`=1 on the first edge, first `peak_evt` at edge 1350, first `zero_evt` at edge 2700. No `zero_evt` is issued at reset release.
- Arithmetic is unsigned CNT_W-bit. `cnt` never exceeds the active P and never wraps.

## Configuration
- `PWM_TIMEBASE_ADC_TRIG_EN`
  - Defined: `adc_trig` logic as described above.
  - Undefined: `adc_trig` is tied to 0, the `adc_trig_pos` comparator is removed, and the port remains present but is ignored.

## Test plan
- Reset release, presc=0, P=1350, `enable`=1 → `peak_evt` at clocks 1350, 4050…; `zero_evt` at 2700, 5400…; `cnt` max 1350.
- Write P=100 at clock 500 → no change until the valley at 2700, where `period_upd`=1 and `zero_evt`=1; the next `peak_evt` follows at 2800.
- presc=3, P=10 → `cnt` steps every 4 clocks, `zero_evt` every 80 clocks, each strobe exactly 1 clock wide.
- `period_wr` with P=50 on the exact valley clock while P=20 is pending → P=20 loads at this valley, P=50 loads at the following valley; `period_wr` with P=0 → active P=2.
- `enable`=0 for 37 clocks mid up-count → `cnt`/`dir` frozen, no strobes; on resume, the event schedule is shifted by exactly 37 clocks.
- `adc_trig_pos`=675, P=1350 → `adc_trig` once per carrier, on the up-count only, when `cnt`=675. With the macro undefined → `adc_trig` stays 0.

Source files
------------

// File: rtl/pwm_timebase.sv
// pwm_timebase: centre-aligned PWM carrier with double-buffered period/prescaler and event strobes
//
// Optional feature macro: PWM_TIMEBASE_ADC_TRIG_EN
//   defined   -> adc_trig pulses when the up-counting carrier reaches adc_trig_pos
//   undefined -> adc_trig tied low, adc_trig_pos ignored
//
// Ports:
//   clk          54 MHz PLL clock
//   rst          synchronous active-high reset
//   enable       1 = carrier runs, 0 = freeze (pending writes still accepted)
//   period_in    new half-period P (values below 2 clamp to 2)
//   period_wr    one-cycle write strobe for period_in/presc_in into the shadow registers
//   presc_in     new prescaler; one tick every presc+1 clocks
//   adc_trig_pos carrier value that fires adc_trig on the up-count
//   cnt          carrier counter (0..P)
//   dir          1 = up, 0 = down
//   zero_evt     pulse when cnt just became 0
//   peak_evt     pulse when cnt just became P
//   period_upd   pulse when the shadow period/prescaler were loaded (coincides with zero_evt)
//   adc_trig     pulse at the ADC sample point
module pwm_timebase #(
  parameter int CNT_W = 16,
  parameter int PRESC_W = 8,
  parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(1350)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [CNT_W-1:0]   period_in,
  input  logic               period_wr,
  input  logic [PRESC_W-1:0] presc_in,
  input  logic [CNT_W-1:0]   adc_trig_pos,
  output logic [CNT_W-1:0]   cnt,
  output logic               dir,
  output logic               zero_evt,
  output logic               peak_evt,
  output logic               period_upd,
  output logic               adc_trig
);
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] period_q, period_d, pend_period_q, pend_period_d;
  logic [PRESC_W-1:0] presc_q, presc_d, pend_presc_q, pend_presc_d;
  logic [PRESC_W-1:0] psc_cnt_q, psc_cnt_d;
  logic dir_q, dir_d, pend_vld_q, pend_vld_d;
  logic zero_q, zero_d, peak_q, peak_d, upd_q, upd_d, adc_q, adc_d;
  logic tick, at_peak, at_valley, load;
  always_comb begin
    tick = enable && (psc_cnt_q == presc_q);
    cnt_inc = cnt_q + 1'b1;
    at_peak = tick && dir_q && (cnt_inc == period_q);
    at_valley = tick && !dir_q && (cnt_q == CNT_W'(1));
    // the valley consumes the shadow contents as they stood before this clock's write
    load = at_valley && pend_vld_q;
    psc_cnt_d = !enable ? psc_cnt_q : tick ? '0 : psc_cnt_q + 1'b1;
    cnt_d = !tick ? cnt_q : dir_q ? cnt_inc : cnt_q - 1'b1;
    dir_d = at_peak ? 1'b0 : at_valley ? 1'b1 : dir_q;
    period_d = load ? pend_period_q : period_q;
    presc_d = load ? pend_presc_q : presc_q;
    pend_period_d = period_wr ? (period_in < CNT_W'(2) ? CNT_W'(2) : period_in) : pend_period_q;
    pend_presc_d = period_wr ? presc_in : pend_presc_q;
    pend_vld_d = period_wr ? 1'b1 : load ? 1'b0 : pend_vld_q;
    zero_d = at_valley;
    peak_d = at_peak;
    upd_d = load;
`ifdef PWM_TIMEBASE_ADC_TRIG_EN
    // up-count hits, plus the valley itself (position 0) which turns the carrier upward
    adc_d = tick && (cnt_d == adc_trig_pos) && (dir_q || at_valley);
`else
    adc_d = 1'b0;
`endif
  end
`ifndef PWM_TIMEBASE_ADC_TRIG_EN
  logic unused_adc_pos;
  assign unused_adc_pos = ^adc_trig_pos;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      dir_q <= 1'b1;
      psc_cnt_q <= '0;
      period_q <= DEFAULT_PERIOD;
      presc_q <= '0;
      pend_period_q <= DEFAULT_PERIOD;
      pend_presc_q <= '0;
      pend_vld_q <= 1'b0;
      zero_q <= 1'b0;
      peak_q <= 1'b0;
      upd_q <= 1'b0;
      adc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      psc_cnt_q <= psc_cnt_d;
      period_q <= period_d;
      presc_q <= presc_d;
      pend_period_q <= pend_period_d;
      pend_presc_q <= pend_presc_d;
      pend_vld_q <= pend_vld_d;
      zero_q <= zero_d;
      peak_q <= peak_d;
      upd_q <= upd_d;
      adc_q <= adc_d;
    end
  end
  assign cnt = cnt_q;
  assign dir = dir_q;
  assign zero_evt = zero_q;
  assign peak_evt = peak_q;
  assign period_upd = upd_q;
  assign adc_trig = adc_q;
endmodule

// File: tb/tb_pwm_timebase.sv
// tb_pwm_timebase: randomized and directed checks of pwm_timebase against a carrier-phase model
module tb_pwm_timebase;
  localparam int CW = 16;
  localparam int PW = 8;
  localparam int DEF = 1350;
`ifdef PWM_TIMEBASE_ADC_TRIG_EN
  localparam bit ADC_EN = 1'b1;
`else
  localparam bit ADC_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic period_wr = 1'b0;
  logic [CW-1:0] period_in = '0;
  logic [CW-1:0] adc_trig_pos = '1;
  logic [PW-1:0] presc_in = '0;
  wire [CW-1:0] cnt;
  wire dir, zero_evt, peak_evt, period_upd, adc_trig;
  pwm_timebase dut (
    .clk(clk), .rst(rst), .enable(enable), .period_in(period_in), .period_wr(period_wr),
    .presc_in(presc_in), .adc_trig_pos(adc_trig_pos), .cnt(cnt), .dir(dir),
    .zero_evt(zero_evt), .peak_evt(peak_evt), .period_upd(period_upd), .adc_trig(adc_trig)
  );
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  // model: carrier phase k in [0, 2P), cnt is the triangle of k; sub is the prescaler position
  int m_k, m_sub, m_p, m_ps, m_pp, m_pps;
  bit m_pv;
  logic [CW+4:0] exp_v;
  wire [CW+4:0] obs = {cnt, dir, zero_evt, peak_evt, period_upd, adc_trig};
  task automatic model_edge();
    bit tk, z, pk, u, a;
    int c;
    z = 0; pk = 0; u = 0; a = 0;
    if (rst) begin
      m_k = 0; m_sub = 0; m_p = DEF; m_ps = 0; m_pv = 0;
    end else begin
      tk = enable && (m_sub == m_ps);
      if (enable) m_sub = tk ? 0 : m_sub + 1;
      if (tk) begin
        m_k++;
        pk = (m_k == m_p);
        if (m_k == 2 * m_p) begin
          m_k = 0;
          z = 1;
          if (m_pv) begin m_p = m_pp; m_ps = m_pps; m_pv = 0; u = 1; end
        end
        a = ADC_EN && (m_k <= m_p) && (m_k == int'(adc_trig_pos));
      end
      if (period_wr) begin
        m_pp = (period_in < 2) ? 2 : int'(period_in);
        m_pps = int'(presc_in);
        m_pv = 1;
      end
    end
    c = (m_k <= m_p) ? m_k : 2 * m_p - m_k;
    exp_v = {CW'(c), m_k < m_p, z, pk, u, a};
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask
  task automatic test_reset();
    rst = 1; enable = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    end
    total++; if (cnt !== 16'd0 || dir !== 1'b1) begin bad++; $display("FAIL reset_vals cnt=%0d dir=%0d exp cnt=0 dir=1", cnt, dir); end
  endtask
  task automatic test_default_carrier();
    int fp, fz, lp, mx;
    fp = -1; fz = -1; lp = -1; mx = 0;
    rst = 0;
    for (int n = 1; n <= 5400; n++) begin
      step();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL default cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (peak_evt && fp < 0) fp = n;
      if (peak_evt) lp = n;
      if (zero_evt && fz < 0) fz = n;
      if (int'(cnt) > mx) mx = int'(cnt);
    end
    total++; if (fp != 1350) begin bad++; $display("FAIL first_peak got=%0d exp=1350", fp); end
    total++; if (fz != 2700) begin bad++; $display("FAIL first_zero got=%0d exp=2700", fz); end
    total++; if (lp != 4050) begin bad++; $display("FAIL second_peak got=%0d exp=4050", lp); end
    total++; if (mx != 1350) begin bad++; $display("FAIL cnt_max got=%0d exp=1350", mx); end
  endtask
  task automatic test_period_write();
    int up, pk;
    up = -1; pk = -1;
    rst = 1; step(); rst = 0;
    for (int n = 1; n <= 2900; n++) begin
      if (n == 500) begin period_wr = 1; period_in = 100; presc_in = 0; end
      step();
      period_wr = 0;
      total++; if (obs !== exp_v) begin bad++; $display("FAIL pwrite cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (period_upd && up < 0) up = n;
      if (peak_evt && n > 2700 && pk < 0) pk = n;
    end
    total++; if (up != 2700) begin bad++; $display("FAIL pwrite_upd got=%0d exp=2700", up); end
    total++; if (pk != 2800) begin bad++; $display("FAIL pwrite_peak got=%0d exp=2800", pk); end
  endtask
  task automatic test_prescaler();
    int zq[$];
    bit seen;
    seen = 0;
    period_in = 10; presc_in = 3; period_wr = 1;
    step();
    period_wr = 0;
    total++; if (obs !== exp_v) begin bad++; $display("FAIL presc cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    for (int n = 0; n < 400; n++) begin
      step();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL presc cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (period_upd) seen = 1;
      if (zero_evt && seen) zq.push_back(cyc);
    end
    total++;
    if (zq.size() < 3) begin bad++; $display("FAIL presc_zeros got=%0d exp>=3", zq.size()); end
    else if (zq[1] - zq[0] != 80 || zq[2] - zq[1] != 80) begin
      bad++; $display("FAIL presc_spacing got=%0d,%0d exp=80,80", zq[1] - zq[0], zq[2] - zq[1]);
    end
  endtask
  task automatic test_valley_write();
    int t0, n;
    bit found;
    period_in = 20; presc_in = 0; period_wr = 1;
    step();
    period_wr = 0;
    total++; if (obs !== exp_v) begin bad++; $display("FAIL vwrite cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    found = 0;
    for (n = 0; n < 300 && !found; n++) begin
      if (enable && m_sub == m_ps && m_k == 2 * m_p - 1) found = 1;
      else begin
        step();
        total++; if (obs !== exp_v) begin bad++; $display("FAIL vwrite cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      end
    end
    total++; if (!found) begin bad++; $display("FAIL vwrite_find got=timeout exp=valley"); end
    period_in = 50; period_wr = 1;
    step();
    period_wr = 0;
    total++; if (obs !== exp_v) begin bad++; $display("FAIL vwrite cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    total++; if (period_upd !== 1'b1 || zero_evt !== 1'b1) begin bad++; $display("FAIL vwrite_load20 got upd=%0d zero=%0d exp=1,1", period_upd, zero_evt); end
    t0 = cyc;
    for (n = 0; n < 300; n++) begin
      step();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL vwrite cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (zero_evt) break;
    end
    total++; if (cyc - t0 != 40 || period_upd !== 1'b1) begin bad++; $display("FAIL vwrite_load50 got=%0d upd=%0d exp=40 upd=1", cyc - t0, period_upd); end
    period_in = 0; period_wr = 1;
    step();
    period_wr = 0;
    total++; if (obs !== exp_v) begin bad++; $display("FAIL vwrite cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    for (n = 0; n < 300; n++) begin
      step();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL vwrite cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (zero_evt) break;
    end
    total++; if (period_upd !== 1'b1) begin bad++; $display("FAIL vwrite_load2 got upd=%0d exp=1", period_upd); end
    t0 = cyc;
    for (n = 0; n < 50; n++) begin
      step();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL vwrite cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (zero_evt) break;
    end
    total++; if (cyc - t0 != 4) begin bad++; $display("FAIL vwrite_p2 got=%0d exp=4", cyc - t0); end
  endtask
  task automatic test_enable_freeze();
    int pred, n;
    period_in = 200; presc_in = 0; period_wr = 1;
    step();
    period_wr = 0;
    for (n = 0; n < 600; n++) begin
      step();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL freeze cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (period_upd) break;
    end
    for (n = 0; n < 600; n++) begin
      step();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL freeze cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (m_k == 50) break;
    end
    pred = cyc + 150;
    enable = 0;
    for (n = 0; n < 37; n++) begin
      step();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL freeze cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    end
    total++; if (cnt !== 16'd50 || dir !== 1'b1) begin bad++; $display("FAIL freeze_hold got cnt=%0d dir=%0d exp cnt=50 dir=1", cnt, dir); end
    enable = 1;
    for (n = 0; n < 400; n++) begin
      step();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL freeze cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (peak_evt) break;
    end
    total++; if (cyc != pred + 37) begin bad++; $display("FAIL freeze_shift got=%0d exp=%0d", cyc, pred + 37); end
  endtask
  task automatic test_adc();
    int na, n;
    na = 0;
    adc_trig_pos = 675; period_in = 1350; presc_in = 0; period_wr = 1;
    step();
    period_wr = 0;
    for (n = 0; n < 600; n++) begin
      step();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL adc cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (period_upd) break;
    end
    for (n = 0; n < 5400; n++) begin
      step();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL adc cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (adc_trig) begin
        na++;
        total++; if (cnt !== 16'd675 || dir !== 1'b1) begin bad++; $display("FAIL adc_point got cnt=%0d dir=%0d exp cnt=675 dir=1", cnt, dir); end
      end
    end
    total++; if (na != (ADC_EN ? 2 : 0)) begin bad++; $display("FAIL adc_count got=%0d exp=%0d", na, ADC_EN ? 2 : 0); end
  endtask
  task automatic test_reset_mid();
    int fp;
    fp = -1;
    period_in = 10; presc_in = 2; period_wr = 1;
    step();
    period_wr = 0;
    rst = 1; step(); rst = 0;
    total++; if (obs !== exp_v) begin bad++; $display("FAIL rstmid cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    for (int n = 1; n <= 1400; n++) begin
      step();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL rstmid cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (peak_evt && fp < 0) fp = n;
    end
    total++; if (fp != 1350) begin bad++; $display("FAIL rstmid_peak got=%0d exp=1350", fp); end
  endtask
  task automatic test_random();
    for (int n = 0; n < 8000; n++) begin
      rst = ($urandom_range(0, 1999) == 0);
      enable = ($urandom_range(0, 9) != 0);
      period_wr = ($urandom_range(0, 39) == 0);
      period_in = CW'($urandom_range(0, 40));
      presc_in = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) adc_trig_pos = CW'($urandom_range(0, 42));
      step();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    end
    rst = 0; enable = 1; period_wr = 0;
  endtask
  initial begin
    test_reset();
    test_default_carrier();
    test_period_write();
    test_prescaler();
    test_valley_write();
    test_enable_freeze();
    test_adc();
    test_reset_mid();
    adc_trig_pos = 0; period_in = 5; presc_in = 0; period_wr = 1;
    step();
    period_wr = 0;
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
